// File: rtl/btn_pkg.sv
// Shared definitions for the push-button conditioner: repeat FSM encoding,
// board-rate timing defaults and shortened constants for simulation.
package btn_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } rep_state_t;

  // 100 MHz board timing: 10 ms debounce, 250 ms first repeat, 50 ms rate.
  localparam int DEF_DEBOUNCE_CYCLES = 1000000;
  localparam int DEF_REPEAT_DELAY    = 25000000;
  localparam int DEF_REPEAT_RATE     = 5000000;

  localparam int SIM_DEBOUNCE_CYCLES = 4;
  localparam int SIM_REPEAT_DELAY    = 6;
  localparam int SIM_REPEAT_RATE     = 3;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/btn_channel.sv
// One button: 2-FF sync, counter debounce, press/release pulses, auto-repeat.
// btn_level/press/release move DEBOUNCE_CYCLES+2 edges after btn_in; all outputs registered.
module btn_channel
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_RATE     = DEF_REPEAT_RATE
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  input  logic repeat_en,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release,
  output logic btn_act
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RW = $clog2(max_int(REPEAT_DELAY, REPEAT_RATE) + 1);
  localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] RD_LAST  = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RR_LAST  = RW'(REPEAT_RATE - 1);

  logic          s1, s2;
  logic [DW-1:0] db_cnt;
  logic [RW-1:0] rep_cnt;
  rep_state_t    state;
  logic          change, rise, fall;

  // Level change accepted on this edge; drives the edge pulses and the FSM.
  assign change = (s2 != btn_level) && (db_cnt == DB_LAST);
  assign rise   = change & s2;
  assign fall   = change & ~s2;

  always_ff @(posedge clk) begin
    if (!rst) begin
      s1          <= 1'b0;
      s2          <= 1'b0;
      db_cnt      <= '0;
      btn_level   <= 1'b0;
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
      btn_act     <= 1'b0;
      rep_cnt     <= '0;
      state       <= IDLE;
    end else begin
      s1 <= btn_in;
      s2 <= s1;

      if ((s2 == btn_level) || change) db_cnt <= '0;
      else                             db_cnt <= db_cnt + 1'b1;

      if (change) btn_level <= s2;
      btn_press   <= rise;
      btn_release <= fall;
      btn_act     <= rise;

      if (rise) begin
        state   <= DELAY;
        rep_cnt <= '0;
      end else if (fall) begin
        state   <= IDLE;
        rep_cnt <= '0;
      end else begin
        case (state)
          DELAY: begin
            if (!repeat_en || !btn_level) begin
              rep_cnt <= '0;
            end else if (rep_cnt == RD_LAST) begin
              btn_act <= 1'b1;
              rep_cnt <= '0;
              state   <= REPEAT;
            end else begin
              rep_cnt <= rep_cnt + 1'b1;
            end
          end
          REPEAT: begin
            if (!repeat_en || !btn_level) begin
              rep_cnt <= '0;
            end else if (rep_cnt == RR_LAST) begin
              btn_act <= 1'b1;
              rep_cnt <= '0;
            end else begin
              rep_cnt <= rep_cnt + 1'b1;
            end
          end
          default: begin
            rep_cnt <= '0;
            state   <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/btn_conditioner.sv
// N_BTN independent button channels for the player controls.
// Outputs registered; level/press/release lag btn_in by DEBOUNCE_CYCLES+2 edges.
module btn_conditioner
  import btn_pkg::*;
#(
  parameter int N_BTN           = 4,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_RATE     = DEF_REPEAT_RATE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_in,
  input  logic [N_BTN-1:0] repeat_en,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_act
);

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    btn_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_RATE    (REPEAT_RATE)
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .btn_in     (btn_in[i]),
      .repeat_en  (repeat_en[i]),
      .btn_level  (btn_level[i]),
      .btn_press  (btn_press[i]),
      .btn_release(btn_release[i]),
      .btn_act    (btn_act[i])
    );
  end

endmodule

// File: tb/tb_btn_conditioner.sv
// Scoreboard bench: a per-edge reference model queues the expected outputs,
// a monitor pops and compares them just after every rising edge.
module tb_btn_conditioner;
  import btn_pkg::*;

  localparam int N  = 4;
  localparam int D  = SIM_DEBOUNCE_CYCLES;
  localparam int RD = SIM_REPEAT_DELAY;
  localparam int RR = SIM_REPEAT_RATE;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [N-1:0] btn_in = '0;
  logic [N-1:0] repeat_en = '0;
  logic [N-1:0] btn_level, btn_press, btn_release, btn_act;

  always #5 clk = ~clk;

  btn_conditioner #(
    .N_BTN          (N),
    .DEBOUNCE_CYCLES(D),
    .REPEAT_DELAY   (RD),
    .REPEAT_RATE    (RR)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_in     (btn_in),
    .repeat_en  (repeat_en),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release),
    .btn_act    (btn_act)
  );

  typedef struct packed {
    logic [N-1:0] level;
    logic [N-1:0] press;
    logic [N-1:0] rel;
    logic [N-1:0] act;
  } obs_t;

  obs_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;

  // Reference model state: raw inputs seen in the last two edges, stable
  // level, length of the current disagreeing run, and hold/repeat timing.
  logic [N-1:0] hist_q[$];
  bit           lvl[N];
  bit           held[N];
  int           run[N];
  int           gap[N];
  int           target[N];

  always @(posedge clk) begin
    obs_t         e;
    logic [N-1:0] view;
    e = '0;
    if (!rst) begin
      hist_q = {};
      hist_q.push_back('0);
      hist_q.push_back('0);
      for (int ch = 0; ch < N; ch++) begin
        lvl[ch] = 0; held[ch] = 0; run[ch] = 0; gap[ch] = 0; target[ch] = RD;
      end
    end else begin
      view = hist_q.pop_front();
      hist_q.push_back(btn_in);
      for (int ch = 0; ch < N; ch++) begin
        if (view[ch] != lvl[ch]) begin
          run[ch]++;
          if (run[ch] == D) begin
            lvl[ch] = view[ch];
            run[ch] = 0;
            if (view[ch]) e.press[ch] = 1'b1;
            else          e.rel[ch]   = 1'b1;
          end
        end else begin
          run[ch] = 0;
        end
        if (e.press[ch]) begin
          held[ch] = 1; gap[ch] = 0; target[ch] = RD; e.act[ch] = 1'b1;
        end else if (e.rel[ch]) begin
          held[ch] = 0;
        end else if (held[ch]) begin
          if (!repeat_en[ch]) begin
            gap[ch] = 0;
          end else begin
            gap[ch]++;
            if (gap[ch] == target[ch]) begin
              e.act[ch] = 1'b1; gap[ch] = 0; target[ch] = RR;
            end
          end
        end
      end
    end
    for (int ch = 0; ch < N; ch++) e.level[ch] = lvl[ch];
    exp_q.push_back(e);
  end

  obs_t m_exp, m_got;

  always @(posedge clk) begin
    #1;
    cyc++;
    tests++;
    if (exp_q.size() == 0) begin
      fails++;
      $display("FAIL scoreboard_empty cycle=%0d", cyc);
    end else begin
      m_exp = exp_q.pop_front();
      m_got = {btn_level, btn_press, btn_release, btn_act};
      if (m_got !== m_exp)begin
        fails++;
        $display("FAIL outputs cycle=%0d got lvl=%b prs=%b rel=%b act=%b exp lvl=%b prs=%b rel=%b act=%b",
                 cyc, m_got.level, m_got.press, m_got.rel, m_got.act,
                 m_exp.level, m_exp.press, m_exp.rel, m_exp.act);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    // Reset with all buttons held, then the fresh press after release of rst.
    btn_in = 4'hF;
    step(3);
    rst = 1'b1;
    step(12);
    btn_in = '0;
    step(12);

    // Short glitch on channel 0.
    btn_in = 4'b0001;
    step(3);
    btn_in = '0;
    step(10);

    // Clean press/release without repeat.
    btn_in = 4'b0001;
    step(20);
    btn_in = '0;
    step(12);

    // Auto-repeat on channel 1.
    repeat_en = 4'b0010;
    btn_in    = 4'b0010;
    step(30);
    btn_in = '0;
    step(12);

    // repeat_en dropped mid-REPEAT, then restored.
    btn_in = 4'b0010;
    step(17);
    repeat_en = '0;
    step(5);
    repeat_en = 4'b0010;
    step(12);
    btn_in = '0;
    step(12);
    repeat_en = '0;

    // Simultaneous presses.
    btn_in = 4'b0101;
    step(10);
    btn_in = '0;
    step(12);

    // Reset while held: fresh press after rst returns.
    repeat_en = 4'b0011;
    btn_in    = 4'hF;
    step(14);
    rst = 1'b0;
    step(2);
    rst = 1'b1;
    step(16);
    btn_in = '0;
    step(12);

    // Random segments: mixes glitches, holds and repeat_en changes.
    for (int i = 0; i < 60; i++) begin
      btn_in    = N'($urandom);
      repeat_en = N'($urandom);
      step($urandom_range(1, 16));
    end
    btn_in = '0;
    step(12);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/btn_conditioner.md
Name: btn_conditioner

Overview:
- Parametrised front end for the player push-buttons (move left, move right, shoot, game reset).
- Each channel is conditioned independently: 2-FF synchroniser, counter debounce, press/release edge pulses, optional per-channel auto-repeat.
- Sits between the raw board buttons and the game FSM/player logic in the space_invaders top, replacing ad-hoc per-button debouncing.
- Auto-repeat serves held left/right movement; shoot and reset run with repeat disabled for one action per press.

Parameters:
- N_BTN, 4, number of button channels.
- DEBOUNCE_CYCLES, 1000000, consecutive disagreeing cycles before a level change is accepted (10 ms at 100 MHz); must be >= 1.
- REPEAT_DELAY, 25000000, hold cycles after a press before the first repeat pulse (250 ms); must be >= 1.
- REPEAT_RATE, 5000000, cycles between subsequent repeat pulses (50 ms); must be >= 1.

Ports:
- clk  in  1  system clock, 100 MHz.
- rst  in  1  synchronous, active-low reset (rst=0 resets on the next rising clk edge).
- btn_in  in  N_BTN  raw asynchronous button levels, 1 = pressed.
- repeat_en  in  N_BTN  per-channel auto-repeat enable, synchronous to clk.
- btn_level  out  N_BTN  debounced level.
- btn_press  out  N_BTN  1-cycle pulse on debounced 0->1.
- btn_release  out  N_BTN  1-cycle pulse on debounced 1->0.
- btn_act  out  N_BTN  action strobe: press pulse plus repeat pulses when enabled.

Behaviour:
- Reset: synchroniser FFs, debounce counters, repeat counters and all outputs go to 0. Repeat FSM goes to IDLE.
- Synchroniser: s1 <= btn_in; s2 <= s1. Both are sync-reset.
- Debounce, per channel:
  - If s2 == btn_level, the counter clears to 0.
  - Otherwise the counter increments.
  - On the edge where the counter == DEBOUNCE_CYCLES-1 and s2 != btn_level, btn_level <= s2 and the counter clears.
  - Latency: btn_level changes on the (DEBOUNCE_CYCLES+2)th rising edge, counting the first edge that samples the new btn_in value.
  - Any glitch shorter than DEBOUNCE_CYCLES cycles at s2 is fully ignored.
  - Counter width is $clog2(DEBOUNCE_CYCLES+1).
- Edge pulses:
  - btn_press and btn_release are registered and assert on the same edge that btn_level changes, for exactly 1 cycle.
  - press and release can never assert together on one channel.
- Repeat FSM, per channel, states IDLE, DELAY, REPEAT:
  - IDLE -> DELAY on the press edge; the repeat counter clears.
  - DELAY, level=1, repeat_en=1: counter increments. When counter == REPEAT_DELAY-1: btn_act pulse, counter clears, next state REPEAT.
  - REPEAT, level=1, repeat_en=1: counter increments. When counter == REPEAT_RATE-1: btn_act pulse, counter clears.
  - repeat_en=0 in DELAY or REPEAT: counter holds at 0 and the state holds. Re-enabling restarts the count from 0 in the current state.
  - btn_level=0 (release edge) from any state: next state IDLE, counter clears, no btn_act that cycle.
- btn_act = btn_press OR repeat pulse.
  - The press pulse always appears on btn_act, regardless of repeat_en.
  - Repeat pulses are registered, 1 cycle wide, and never coincide with the press pulse.
- Channels are fully independent. Simultaneous presses on several channels each produce their own pulses on the same edge.
- Reset mid-hold: everything clears. A button still held after rst returns high reports a fresh press DEBOUNCE_CYCLES+2 cycles later.
- No combinational path from any input to any output.

Decomposition:
- Shared package btn_pkg:
  - FSM state encoding: IDLE=2'd0, DELAY=2'd1, REPEAT=2'd2.
  - Default timing constants at 100 MHz.
  - Simulation-scale constants: DEBOUNCE_CYCLES=4, REPEAT_DELAY=6, REPEAT_RATE=3.
- Sub-module btn_channel: one channel (sync, debounce, edges, repeat FSM) with the same timing parameters.
- btn_conditioner instantiates N_BTN copies in a generate loop.

Test Plan (DEBOUNCE_CYCLES=4, REPEAT_DELAY=6, REPEAT_RATE=3, N_BTN=4):
- Reset: hold rst=0 for 3 cycles with btn_in=4'hF -> all outputs 0. After rst=1, btn_level=4'hF and btn_press=4'hF for one cycle exactly 6 edges later.
- Glitch rejection: btn_in[0] high for 3 cycles then low -> btn_level[0], btn_press[0] and btn_act[0] stay 0 throughout.
- Clean press/release, repeat_en=0: press held 20 cycles -> btn_press[0] and btn_act[0] pulse once, 6 edges after the input rise. btn_release[0] pulses 6 edges after the input fall. No other btn_act.
- Auto-repeat, repeat_en[1]=1, hold 30 cycles -> btn_act[1] pulses at press edge P, then at P+6, P+9, P+12, ... until the release edge. No pulse on the release cycle.
- repeat_en toggle: drop repeat_en[1] to 0 for 5 cycles mid-REPEAT -> no btn_act during that window. The first pulse arrives 3 cycles after re-enable.
- Simultaneous channels: btn_in=4'b0101 on one edge -> btn_press=4'b0101 on a single cycle. Channels 1 and 3 remain 0.
